// File: rtl/mmio_hub_pkg.sv
// Shared constants for the MMIO hub: address decode fields, region codes,
// per-region register indices and timer control bit positions.
`timescale 1ns/1ps
package mmio_hub_pkg;

  // addr[31:28] value that selects the IO space
  localparam logic [3:0] IO_BASE = 4'hF;

  // IO region, taken from addr[27:24]
  typedef enum logic [3:0] {
    RGN_SEG   = 4'd0,
    RGN_LED   = 4'd1,
    RGN_SW    = 4'd2,
    RGN_KEY   = 4'd3,
    RGN_TIMER = 4'd4
  } region_e;

  // Word indices (addr[7:2]) within each region
  localparam logic [5:0] SW_IDX_VALUE   = 6'd0;
  localparam logic [5:0] KEY_IDX_LEVEL  = 6'd0;
  localparam logic [5:0] KEY_IDX_PEND   = 6'd1;
  localparam logic [5:0] KEY_IDX_MASK   = 6'd2;
  localparam logic [5:0] TMR_IDX_COUNT  = 6'd0;
  localparam logic [5:0] TMR_IDX_CMP    = 6'd1;
  localparam logic [5:0] TMR_IDX_CTRL   = 6'd2;
  localparam logic [5:0] TMR_IDX_STATUS = 6'd3;

  // Timer control register layout
  localparam int CTRL_W      = 3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/io_sync.sv
// Two-flop synchroniser for asynchronous board inputs, with a configurable
// reset value so the synchronised level starts in a known idle state.
`timescale 1ns/1ps
module io_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage shift toward q; the first stage may go metastable
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped IO hub: splits CPU accesses between data memory and a small
// IO space holding seven-segment digits, LEDs, switches, keys and a timer.
`timescale 1ns/1ps
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int N_SEG = 6,
  parameter int N_LED = 10,
  parameter int N_SW  = 10,
  parameter int N_KEY = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [31:0]        addr,
  input  logic [31:0]        datain,
  input  logic               we,
  input  logic [31:0]        memout,
  output logic [31:0]        dataout,
  output logic               wmem,
  output logic [4*N_SEG-1:0] seg_out,
  output logic [N_LED-1:0]   led_out,
  input  logic [N_SW-1:0]    sw_in,
  input  logic [N_KEY-1:0]   key_in,
  output logic               irq
);

  // ---------------- address decode ----------------
  logic       is_io;
  region_e    region;
  logic [5:0] idx;
  logic       io_we;
  logic       wr_seg, wr_led, wr_key, wr_tmr;
  logic       unused_addr;

  assign is_io  = (addr[31:28] == IO_BASE);
  assign region = region_e'(addr[27:24]);
  assign idx    = addr[7:2];
  assign io_we  = we & is_io;
  assign wmem   = we & ~is_io;
  assign wr_seg = io_we && (region == RGN_SEG);
  assign wr_led = io_we && (region == RGN_LED);
  assign wr_key = io_we && (region == RGN_KEY);
  assign wr_tmr = io_we && (region == RGN_TIMER);
  assign unused_addr = ^{addr[23:8], addr[1:0]};

  // ---------------- state ----------------
  logic [3:0]        seg_q [N_SEG];
  logic [N_LED-1:0]  led_q;
  logic [N_SW-1:0]   sw_sync;
  logic [N_KEY-1:0]  key_pressed, key_prev, key_rise;
  logic [N_KEY-1:0]  key_pend, key_pend_nxt, key_mask, key_w1c;
  logic [31:0]       tmr_count, tmr_count_nxt, tmr_cmp;
  logic [CTRL_W-1:0] tmr_ctrl;
  logic              tmr_match, tmr_match_nxt, tmr_hit;
  logic              irq_nxt;
  logic [31:0]       io_rdata;

  io_sync #(.WIDTH(N_SW)) u_sw_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (sw_in),
    .q      (sw_sync)
  );

  // Keys are inverted before synchronising, so the all-zero reset value
  // means "released" and no false press edge appears after reset.
  io_sync #(.WIDTH(N_KEY)) u_key_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (~key_in),
    .q      (key_pressed)
  );

  // Digit and LED registers, written by CPU stores to in-range indices
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: this register file is small and visible on pins, so every entry
      // is reset; large RAM arrays would normally be left unreset.
      for (int i = 0; i < N_SEG; i++) seg_q[i] <= '0;
      led_q <= '0;
    end else begin
      // NOTE: sequential state always uses <=, so every flop samples the
      // pre-edge values regardless of statement order.
      for (int i = 0; i < N_SEG; i++)
        if (wr_seg && idx == 6'(i)) seg_q[i] <= datain[3:0];
      for (int i = 0; i < N_LED; i++)
        if (wr_led && idx == 6'(i)) led_q[i] <= datain[0];
    end
  end

  // Pending-bit update: new press edges win over a coincident clear
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value unassigned
    // (which would infer a latch).
    key_w1c  = '0;
    key_rise = key_pressed & ~key_prev;
    if (wr_key && idx == KEY_IDX_PEND) key_w1c = datain[N_KEY-1:0];
    key_pend_nxt = (key_pend & ~key_w1c) | key_rise;
  end

  // Key edge history, sticky pending bits and interrupt mask
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_prev <= '0;
      key_pend <= '0;
      key_mask <= '0;
    end else begin
      key_prev <= key_pressed;
      key_pend <= key_pend_nxt;
      if (wr_key && idx == KEY_IDX_MASK) key_mask <= datain[N_KEY-1:0];
    end
  end

  // Timer next state: CPU count write beats increment/reload; match is
  // judged on the count as it stood before any write this cycle
  always_comb begin
    tmr_hit       = tmr_ctrl[CTRL_EN] && (tmr_count == tmr_cmp);
    tmr_count_nxt = tmr_count;
    if (wr_tmr && idx == TMR_IDX_COUNT)
      tmr_count_nxt = datain;
    else if (tmr_ctrl[CTRL_EN])
      tmr_count_nxt = (tmr_hit && tmr_ctrl[CTRL_RELOAD]) ? 32'd0 : tmr_count + 32'd1;
    tmr_match_nxt = tmr_hit |
                    (tmr_match & ~(wr_tmr && idx == TMR_IDX_STATUS && datain[0]));
  end

  // Timer registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmr_count <= '0;
      tmr_cmp   <= '0;
      tmr_ctrl  <= '0;
      tmr_match <= 1'b0;
    end else begin
      tmr_count <= tmr_count_nxt;
      tmr_match <= tmr_match_nxt;
      if (wr_tmr && idx == TMR_IDX_CMP)  tmr_cmp  <= datain;
      if (wr_tmr && idx == TMR_IDX_CTRL) tmr_ctrl <= datain[CTRL_W-1:0];
    end
  end

  // Interrupt sources combined, then registered onto the irq pin
  assign irq_nxt = (|(key_pend & key_mask)) | (tmr_match & tmr_ctrl[CTRL_IRQ_EN]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= irq_nxt;
  end

  // IO read mux; anything unmapped reads as zero
  always_comb begin
    io_rdata = '0;
    case (region)
      RGN_SEG:
        for (int i = 0; i < N_SEG; i++)
          if (idx == 6'(i)) io_rdata[3:0] = seg_q[i];
      RGN_LED:
        for (int i = 0; i < N_LED; i++)
          if (idx == 6'(i)) io_rdata[0] = led_q[i];
      RGN_SW:
        if (idx == SW_IDX_VALUE) io_rdata[N_SW-1:0] = sw_sync;
      RGN_KEY:
        case (idx)
          KEY_IDX_LEVEL: io_rdata[N_KEY-1:0] = key_pressed;
          KEY_IDX_PEND:  io_rdata[N_KEY-1:0] = key_pend;
          KEY_IDX_MASK:  io_rdata[N_KEY-1:0] = key_mask;
          default:       io_rdata = '0;
        endcase
      RGN_TIMER:
        case (idx)
          TMR_IDX_COUNT:  io_rdata = tmr_count;
          TMR_IDX_CMP:    io_rdata = tmr_cmp;
          TMR_IDX_CTRL:   io_rdata[CTRL_W-1:0] = tmr_ctrl;
          TMR_IDX_STATUS: io_rdata[0] = tmr_match;
          default:        io_rdata = '0;
        endcase
      default: io_rdata = '0;
    endcase
  end

  // Load data to CPU and digit bus flattening
  always_comb begin
    dataout = is_io ? io_rdata : memout;
    seg_out = '0;
    for (int i = 0; i < N_SEG; i++) seg_out[4*i +: 4] = seg_q[i];
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: table-driven register vectors plus
// hand-written sequences for switches, keys, timer and reset behaviour.
`timescale 1ns/1ps
module tb_mmio_hub;

  localparam int N_SEG = 6;
  localparam int N_LED = 10;
  localparam int N_SW  = 10;
  localparam int N_KEY = 4;

  localparam logic [31:0] A_KEY_LEVEL = 32'hF300_0000;
  localparam logic [31:0] A_KEY_PEND  = 32'hF300_0004;
  localparam logic [31:0] A_KEY_MASK  = 32'hF300_0008;
  localparam logic [31:0] A_T_COUNT   = 32'hF400_0000;
  localparam logic [31:0] A_T_CMP     = 32'hF400_0004;
  localparam logic [31:0] A_T_CTRL    = 32'hF400_0008;
  localparam logic [31:0] A_T_STATUS  = 32'hF400_000C;

  logic               clock = 1'b0;
  logic               resetn;
  logic [31:0]        addr, datain, memout, dataout;
  logic               we, wmem, irq;
  logic [4*N_SEG-1:0] seg_out;
  logic [N_LED-1:0]   led_out;
  logic [N_SW-1:0]    sw_in;
  logic [N_KEY-1:0]   key_in;

  always #5 clock = ~clock;

  mmio_hub #(.N_SEG(N_SEG), .N_LED(N_LED), .N_SW(N_SW), .N_KEY(N_KEY)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .memout  (memout),
    .dataout (dataout),
    .wmem    (wmem),
    .seg_out (seg_out),
    .led_out (led_out),
    .sw_in   (sw_in),
    .key_in  (key_in),
    .irq     (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected value is queued when the read is issued, popped when dataout is sampled
  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    sb_item_t it;
    sb.push_back('{name: name, exp: exp});
    addr = a;
    we   = 1'b0;
    #1;
    it = sb.pop_front();
    check(it.name, dataout, it.exp);
  endtask

  // Called at a falling edge; the store commits on the following rising edge
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    @(negedge clock);
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    vecs[0] = '{32'hF000_0008, 32'h0000_000A, 32'h0000_000A}; // digit 2
    vecs[1] = '{32'hF000_0018, 32'h0000_0005, 32'h0000_0000}; // digit 6 out of range
    vecs[2] = '{32'hF000_0000, 32'h0000_001F, 32'h0000_000F}; // only low nibble kept
    vecs[3] = '{32'hF100_0000, 32'h0000_0003, 32'h0000_0001}; // LED 0, bit0 only
    vecs[4] = '{32'hF100_0024, 32'h0000_0001, 32'h0000_0001}; // LED 9, top index
    vecs[5] = '{32'hF100_0028, 32'h0000_0001, 32'h0000_0000}; // LED 10 out of range
    vecs[6] = '{32'hF500_0000, 32'h0000_FFFF, 32'h0000_0000}; // unmapped region
    vecs[7] = '{32'hF200_0000, 32'h0000_0123, 32'h0000_0000}; // switch is read-only

    resetn = 1'b0;
    addr   = 32'h0;
    datain = 32'h0;
    we     = 1'b0;
    memout = 32'h1234_5678;
    sw_in  = '0;
    key_in = '1;
    #1;
    check("rst_seg", 32'(seg_out), 32'h0);
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_wmem", 32'(wmem), 32'h0);
    check("rst_mem_read", dataout, 32'h1234_5678);

    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // ---- table-driven register vectors ----
    for (int i = 0; i < 8; i++) begin
      cpu_write(vecs[i].addr, vecs[i].wdata);
      read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("seg_out_bus", 32'(seg_out), 32'h0000_0A0F);
    check("led_out_bus", 32'(led_out), 32'h0000_0201);

    // ---- switch synchroniser latency ----
    sw_in = 10'h155;
    @(negedge clock);
    read_check("sw_after_1clk", 32'hF200_0000, 32'h0);
    @(negedge clock);
    @(negedge clock);
    read_check("sw_after_3clk", 32'hF200_0000, 32'h0000_0155);

    // ---- key press, pending, irq, W1C ----
    cpu_write(A_KEY_MASK, 32'h2);
    read_check("key_mask", A_KEY_MASK, 32'h2);
    key_in = 4'b1101;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clock);
      addr = A_KEY_PEND;
      #1;
      if (dataout == 32'h2) found = 1'b1;
    end
    check("key_pend_seen", 32'(found), 32'h1);
    check("key_irq_not_yet", 32'(irq), 32'h0);
    read_check("key_level", A_KEY_LEVEL, 32'h2);
    @(negedge clock);
    check("key_irq_set", 32'(irq), 32'h1);
    cpu_write(A_KEY_PEND, 32'h2);
    read_check("key_pend_cleared", A_KEY_PEND, 32'h0);
    @(negedge clock);
    check("key_irq_cleared", 32'(irq), 32'h0);

    // release, then press again with a clear landing on the edge cycle
    key_in = 4'hF;
    repeat (4) @(negedge clock);
    read_check("key_release_no_pend", A_KEY_PEND, 32'h0);
    key_in = 4'b1101;
    @(negedge clock);
    @(negedge clock);
    cpu_write(A_KEY_PEND, 32'h2);
    read_check("key_set_beats_w1c", A_KEY_PEND, 32'h2);
    key_in = 4'hF;
    repeat (4) @(negedge clock);
    cpu_write(A_KEY_PEND, 32'hF);
    cpu_write(A_KEY_MASK, 32'h0);

    // ---- timer: compare 5, enable + reload + irq, period 6 ----
    cpu_write(A_T_CMP, 32'd5);
    cpu_write(A_T_CTRL, 32'h7);
    read_check("tmr_start", A_T_COUNT, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      read_check($sformatf("tmr_cnt_k%0d", k), A_T_COUNT, 32'(k % 6));
      read_check($sformatf("tmr_match_k%0d", k), A_T_STATUS, (k >= 6) ? 32'd1 : 32'd0);
      check($sformatf("tmr_irq_k%0d", k), 32'(irq), (k >= 7) ? 32'd1 : 32'd0);
    end
    cpu_write(A_T_STATUS, 32'h1);
    read_check("tmr_status_w1c", A_T_STATUS, 32'd0);
    check("tmr_irq_lag", 32'(irq), 32'h1);
    @(negedge clock);
    check("tmr_irq_dropped", 32'(irq), 32'h0);

    // ---- count write overrides; match uses the pre-write count ----
    cpu_write(A_T_CTRL, 32'h0);
    cpu_write(A_T_STATUS, 32'h1);
    cpu_write(A_T_COUNT, 32'd10);
    cpu_write(A_T_CMP, 32'd10);
    cpu_write(A_T_CTRL, 32'h1);
    read_check("ovr_count_held", A_T_COUNT, 32'd10);
    read_check("ovr_status_clear", A_T_STATUS, 32'd0);
    cpu_write(A_T_COUNT, 32'd100);
    read_check("ovr_count_written", A_T_COUNT, 32'd100);
    read_check("ovr_match_prewrite", A_T_STATUS, 32'd1);
    @(negedge clock);
    read_check("ovr_count_incr", A_T_COUNT, 32'd101);

    // ---- wrap from all-ones, no reload, compare 3 ----
    cpu_write(A_T_CTRL, 32'h0);
    cpu_write(A_T_STATUS, 32'h1);
    cpu_write(A_T_COUNT, 32'hFFFF_FFFF);
    cpu_write(A_T_CMP, 32'd3);
    cpu_write(A_T_CTRL, 32'h1);
    read_check("wrap_start", A_T_COUNT, 32'hFFFF_FFFF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      read_check($sformatf("wrap_cnt_k%0d", k), A_T_COUNT, 32'(k - 1));
      read_check($sformatf("wrap_match_k%0d", k), A_T_STATUS, (k >= 5) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    check("wrap_no_irq", 32'(irq), 32'h0);

    // ---- asynchronous reset with irq high ----
    cpu_write(A_T_CTRL, 32'h0);
    cpu_write(A_T_STATUS, 32'h1);
    cpu_write(A_T_COUNT, 32'd0);
    cpu_write(A_T_CMP, 32'd2);
    cpu_write(A_T_CTRL, 32'h7);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (irq === 1'b1) found = 1'b1;
    end
    check("rst2_irq_high_before", 32'(found), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst2_irq", 32'(irq), 32'h0);
    check("rst2_seg", 32'(seg_out), 32'h0);
    check("rst2_led", 32'(led_out), 32'h0);
    read_check("rst2_count", A_T_COUNT, 32'h0);
    read_check("rst2_ctrl", A_T_CTRL, 32'h0);

    // memory-side store and load pass-through
    memout = 32'hDEAD_BEEF;
    addr   = 32'h0000_1000;
    datain = 32'h5555_AAAA;
    we     = 1'b1;
    #1;
    check("mem_wmem", 32'(wmem), 32'h1);
    check("mem_dataout", dataout, 32'hDEAD_BEEF);
    addr = 32'hF500_0000;
    #1;
    check("io_store_no_wmem", 32'(wmem), 32'h0);
    we = 1'b0;

    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    @(negedge clock);
    read_check("post_rst_count_idle", A_T_COUNT, 32'h0);
    read_check("post_rst_no_key_edge", A_KEY_PEND, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
